// File: rtl/dense_layer_sequencer_if.sv
// Control and RAM-port bundle between the dense-layer sequencer and its environment.
// The master side is the sequencer; the slave side is the top-level control plus the RAM.
interface dense_layer_sequencer_if #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 24
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_wdata;
    logic [DATA_WIDTH-1:0]    ram_rdata;
    logic [3:0]               pred_class;
    logic [DATA_WIDTH-1:0]    pred_score;

    modport master (
        input  start, ram_rdata,
        output busy, done, ram_we, ram_addr, ram_wdata, pred_class, pred_score
    );
    modport slave (
        output start, ram_rdata,
        input  busy, done, ram_we, ram_addr, ram_wdata, pred_class, pred_score
    );
endinterface

// File: rtl/dense_layer_sequencer.sv
// Sequences one fully-connected layer over a single-port RAM: Y = sat((b + W*X) >>> SHIFT),
// writes each Y back and keeps the running argmax as the predicted class.
module dense_layer_sequencer #(
    parameter int                       ADDRESS_WIDTH = 14,
    parameter int                       DATA_WIDTH    = 24,
    parameter logic [ADDRESS_WIDTH-1:0] X_BASE        = 14'h0000,
    parameter logic [ADDRESS_WIDTH-1:0] W_BASE        = 14'h0310,
    parameter logic [ADDRESS_WIDTH-1:0] B_BASE        = 14'h21B0,
    parameter logic [ADDRESS_WIDTH-1:0] Y_BASE        = 14'h21BA,
    parameter int                       N_IN          = 784,
    parameter int                       N_OUT         = 10,
    parameter int                       ACC_WIDTH     = 56,
    parameter int                       SHIFT         = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    dense_layer_sequencer_if.master bus
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [2:0] {IDLE, RB, LB, RX, RW, MAC, WR, DONE} state_t;

    state_t                        state, nxt;
    logic [IW-1:0]                 i, nxt_i;
    logic [3:0]                    j, nxt_j;
    logic signed [ACC_WIDTH-1:0]   acc, nxt_acc, sh;
    logic signed [DATA_WIDTH-1:0]  x_reg, nxt_x;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]         y, nxt_wdata;
    logic [ADDRESS_WIDTH-1:0]      nxt_addr;
    logic                          nxt_we, nxt_busy;

    assign prod = x_reg * $signed(bus.ram_rdata);

    // Outputs are registered, so they are derived from the state and counters about to be entered.
    always_comb begin
        nxt     = state;
        nxt_i   = i;
        nxt_j   = j;
        nxt_acc = acc;
        nxt_x   = x_reg;
        case (state)
            IDLE: if (bus.start) begin nxt = RB; nxt_j = '0; end
            RB:   nxt = LB;
            LB: begin
                nxt_acc = ACC_WIDTH'($signed(bus.ram_rdata));
                nxt_i   = '0;
                nxt     = RX;
            end
            RX:   nxt = RW;
            RW: begin
                nxt_x = $signed(bus.ram_rdata);
                nxt   = MAC;
            end
            MAC: begin
                nxt_acc = acc + ACC_WIDTH'(prod);
                if (i == IW'(N_IN - 1)) nxt = WR;
                else begin nxt_i = i + 1'b1; nxt = RX; end
            end
            WR: begin
                if (j == 4'(N_OUT - 1)) nxt = DONE;
                else begin nxt_j = j + 1'b1; nxt = RB; end
            end
            default: nxt = IDLE;
        endcase

        sh = nxt_acc >>> SHIFT;
        if (sh > Y_MAX)      y = Y_MAX[DATA_WIDTH-1:0];
        else if (sh < Y_MIN) y = Y_MIN[DATA_WIDTH-1:0];
        else                 y = sh[DATA_WIDTH-1:0];

        nxt_addr  = '0;
        nxt_we    = 1'b0;
        nxt_wdata = bus.ram_wdata;
        nxt_busy  = (nxt != IDLE) && (nxt != DONE);
        case (nxt)
            RB: nxt_addr = B_BASE + ADDRESS_WIDTH'(nxt_j);
            RX: nxt_addr = X_BASE + ADDRESS_WIDTH'(nxt_i);
            RW: nxt_addr = W_BASE + ADDRESS_WIDTH'(32'(nxt_j) * N_IN) + ADDRESS_WIDTH'(nxt_i);
            WR: begin
                nxt_addr  = Y_BASE + ADDRESS_WIDTH'(nxt_j);
                nxt_we    = 1'b1;
                nxt_wdata = y;
            end
            default: nxt_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            i              <= '0;
            j              <= '0;
            acc            <= '0;
            x_reg          <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.pred_class <= '0;
            bus.pred_score <= '0;
        end else begin
            state         <= nxt;
            i             <= nxt_i;
            j             <= nxt_j;
            acc           <= nxt_acc;
            x_reg         <= nxt_x;
            bus.busy      <= nxt_busy;
            bus.done      <= (nxt == DONE);
            bus.ram_we    <= nxt_we;
            bus.ram_addr  <= nxt_addr;
            bus.ram_wdata <= nxt_wdata;
            // Strict compare keeps the lower index on ties; neuron 0 always seeds the argmax.
            if (state == WR && (j == '0 || $signed(bus.ram_wdata) > $signed(bus.pred_score))) begin
                bus.pred_class <= j;
                bus.pred_score <= bus.ram_wdata;
            end
        end
    end
endmodule
